fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch stage plus IF/ID pipeline register; sits directly upstream of the Control decoder.
//  Holds the PC and issues one request at a time to instruction memory (variable response latency).
//  Captures the returned word into IF/ID. Presents id_op_o (inst[31:26]) to Control, and the rest to decode.
//  Supports decode back-pressure (id_ready_i) and branch/jump redirect with flush.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC value loaded at reset
//  ADDR_W    32             PC / instruction address width
// PORTS
//  clk_i             in   1       clock, rising edge
//  rst_i             in   1       reset, asynchronous, active-high
//  start_i           in   1       leave IDLE and begin fetching
//  imem_req_o        out  1       one-cycle request pulse
//  imem_addr_o       out  ADDR_W  request address = PC, low 2 bits always 0
//  imem_rvalid_i     in   1       response valid, at least 1 cycle after imem_req_o
//  imem_rdata_i      in   32      instruction word
//  redirect_i        in   1       branch/jump taken; flush and refetch
//  redirect_pc_i     in   ADDR_W  target; low 2 bits ignored (forced 0)
//  id_ready_i        in   1       decode consumes IF/ID this cycle
//  id_valid_o        out  1       IF/ID holds a valid instruction
//  id_inst_o         out  32      instruction; 32'h0 (NOP) when !id_valid_o
//  id_op_o           out  6       id_inst_o[31:26], to Control Op_i
//  id_pc4_o          out  ADDR_W  PC of the instruction + 4
// BEHAVIOUR
//  Reset: state=IDLE, PC=RESET_PC. All outputs 0; imem_addr_o=RESET_PC.
//  slot_free = !id_valid_o | id_ready_i. Consume = id_valid_o & id_ready_i.
//  FSM:
//   IDLE: start_i -> REQ. redirect_i here only loads PC.
//   REQ:  imem_req_o=1, addr=PC -> WAIT.
//   WAIT: on rvalid & slot_free -> load IF/ID, PC+=4, go to REQ.
//         On rvalid & !slot_free -> latch word into hold buffer, go to HOLD.
//   HOLD: no request. When slot_free -> move buffer into IF/ID, PC+=4, go to REQ.
//   DROP: wait for rvalid, discard it, go to REQ (PC already holds the target).
//  Redirect (highest priority, overrides stall and capture):
//   Clears id_valid_o next cycle; PC <= {redirect_pc_i[ADDR_W-1:2],2'b00}.
//   In REQ, or WAIT without rvalid -> DROP (in-flight response is discarded).
//   In WAIT with rvalid, or in HOLD -> response/buffer discarded, go to REQ.
//   In DROP -> stay in DROP, update PC.
//  Latency: request to IF/ID valid = memory latency + 1 cycle. Peak rate: 1 instr per 2 cycles.
//  IF/ID holds its value while id_valid_o & !id_ready_i. Consume without a new load -> id_valid_o=0, id_inst_o=0.
//  PC+4 wraps modulo 2^ADDR_W. Never more than one outstanding request.
//  rst_i mid-transaction: immediate return to IDLE. A late imem_rvalid_i in IDLE is ignored.
// CONFIGURATION
//  FETCH_PERF_EN defined:
//   Adds perf_fetch_cnt_o[31:0] (+1 per IF/ID load).
//   Adds perf_stall_cnt_o[31:0] (+1 per cycle in HOLD).
//   Both wrap, reset to 0.
//  FETCH_PERF_EN undefined: these ports and counters are absent; behaviour is otherwise identical.
// STRUCTURE
//  Shared package cpu_defs:
//   FETCH_IDLE/REQ/WAIT/HOLD/DROP state encodings (3 bits).
//   OP_W=6, INST_W=32, NOP_INST=32'h0.
//  Sub-module fetch_ifid_reg: IF/ID register (valid/inst/pc4) with load, hold and flush. FSM and PC stay in fetch_unit.
// TESTING
//  1. Reset, start_i; memory latency 1, id_ready_i=1.
//     -> Requests at 0x0,0x4,0x8 every 2 cycles; id_pc4_o=0x4,0x8,0xC.
//  2. id_ready_i=0 while IF/ID valid, rvalid arrives.
//     -> HOLD, no imem_req_o. Raise ready -> buffered word appears the next cycle; no instruction lost or duplicated.
//  3. redirect_i, target 0x40, pulsed in WAIT before rvalid (latency 3).
//     -> Stale response discarded; next request addr=0x40; id_valid_o=0 meanwhile.
//  4. redirect_pc_i=0x43 in HOLD.
//     -> Buffer dropped; request addr=0x40; IF/ID flushed the next cycle.
//  5. RESET_PC=32'hFFFF_FFFC.
//     -> Second request addr=0x0 (wrap).
//  6. rst_i asserted in WAIT, then late rvalid.
//     -> IDLE; outputs 0; IF/ID stays invalid.
//     With FETCH_PERF_EN: counters read 0, then count loads and HOLD cycles exactly.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared fetch/decode definitions: FSM state encodings and instruction-word constants.
package cpu_defs;

  localparam int OP_W   = 6;
  localparam int INST_W = 32;
  localparam logic [INST_W-1:0] NOP_INST = 32'h0;

  typedef enum logic [2:0] {
    FETCH_IDLE = 3'd0,
    FETCH_REQ  = 3'd1,
    FETCH_WAIT = 3'd2,
    FETCH_HOLD = 3'd3,
    FETCH_DROP = 3'd4
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus: fetch drives master, memory drives slave.
interface fetch_unit_if #(parameter int ADDR_W = 32);
  import cpu_defs::*;

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_rvalid;
  logic [INST_W-1:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_rvalid, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_rvalid, imem_rdata);

endinterface

// File: rtl/fetch_unit_ifid_reg.sv
// IF/ID pipeline register: flush beats load beats consume; otherwise holds (decode stall).
// Latency 1 cycle from load to valid; invalid contents always read as NOP.
module fetch_ifid_reg
  import cpu_defs::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              load_i,
  input  logic              consume_i,
  input  logic [INST_W-1:0] inst_i,
  input  logic [ADDR_W-1:0] pc4_i,
  output logic              valid_o,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] pc4_o
);

  logic              valid_q, valid_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [ADDR_W-1:0] pc4_q, pc4_d;

  always_comb begin
    valid_d = valid_q;
    inst_d  = inst_q;
    pc4_d   = pc4_q;
    if (flush_i) begin
      valid_d = 1'b0;
      inst_d  = NOP_INST;
      pc4_d   = '0;
    end else if (load_i) begin
      valid_d = 1'b1;
      inst_d  = inst_i;
      pc4_d   = pc4_i;
    end else if (consume_i) begin
      valid_d = 1'b0;
      inst_d  = NOP_INST;
      pc4_d   = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      inst_q  <= NOP_INST;
      pc4_q   <= '0;
    end else begin
      valid_q <= valid_d;
      inst_q  <= inst_d;
      pc4_q   <= pc4_d;
    end
  end

  assign valid_o = valid_q;
  assign inst_o  = inst_q;
  assign pc4_o   = pc4_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage + IF/ID: one outstanding imem request, memory latency + 1 to IF/ID, decode stall parks word in HOLD.
// Optional FETCH_PERF_EN adds fetch/stall performance counters.
module fetch_unit
  import cpu_defs::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  fetch_unit_if.master      imem,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  input  logic              id_ready_i,
  output logic              id_valid_o,
  output logic [INST_W-1:0] id_inst_o,
  output logic [OP_W-1:0]   id_op_o,
  output logic [ADDR_W-1:0] id_pc4_o
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetch_cnt_o,
  output logic [31:0]       perf_stall_cnt_o
`endif
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK  = ~ADDR_W'(3);
  localparam logic [ADDR_W-1:0] RESET_PC_AL = RESET_PC & ALIGN_MASK;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, pc_plus4, redir_pc;
  logic [INST_W-1:0] hold_q, hold_d, load_inst;
  logic              slot_free, load, req;

  assign pc_plus4  = pc_q + ADDR_W'(4);
  assign redir_pc  = redirect_pc_i & ALIGN_MASK;
  assign slot_free = !id_valid_o | id_ready_i;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    hold_d    = hold_q;
    load      = 1'b0;
    load_inst = hold_q;
    req       = 1'b0;
    unique case (state_q)
      FETCH_IDLE: if (start_i) state_d = FETCH_REQ;
      FETCH_REQ: begin
        req     = 1'b1;
        state_d = FETCH_WAIT;
      end
      FETCH_WAIT: begin
        if (imem.imem_rvalid) begin
          if (slot_free) begin
            load      = 1'b1;
            load_inst = imem.imem_rdata;
            pc_d      = pc_plus4;
            state_d   = FETCH_REQ;
          end else begin
            hold_d  = imem.imem_rdata;
            state_d = FETCH_HOLD;
          end
        end
      end
      FETCH_HOLD: begin
        if (slot_free) begin
          load    = 1'b1;
          pc_d    = pc_plus4;
          state_d = FETCH_REQ;
        end
      end
      FETCH_DROP: if (imem.imem_rvalid) state_d = FETCH_REQ;
      default: state_d = FETCH_IDLE;
    endcase

    // Redirect wins over capture/stall. A response arriving in the same cycle
    // retires the outstanding request, so DROP is only needed while one is still in flight.
    if (redirect_i) begin
      load = 1'b0;
      pc_d = redir_pc;
      case (state_q)
        FETCH_REQ:  state_d = FETCH_DROP;
        FETCH_WAIT: state_d = imem.imem_rvalid ? FETCH_REQ : FETCH_DROP;
        FETCH_DROP: state_d = imem.imem_rvalid ? FETCH_REQ : FETCH_DROP;
        FETCH_HOLD: state_d = FETCH_REQ;
        default: begin end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= FETCH_IDLE;
      pc_q    <= RESET_PC_AL;
      hold_q  <= NOP_INST;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
    end
  end

  assign imem.imem_req  = req;
  assign imem.imem_addr = pc_q;

  fetch_ifid_reg #(.ADDR_W(ADDR_W)) u_ifid (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .flush_i   (redirect_i),
    .load_i    (load),
    .consume_i (id_valid_o & id_ready_i),
    .inst_i    (load_inst),
    .pc4_i     (pc_plus4),
    .valid_o   (id_valid_o),
    .inst_o    (id_inst_o),
    .pc4_o     (id_pc4_o)
  );

  assign id_op_o = id_inst_o[INST_W-1:INST_W-OP_W];

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d, stall_cnt_q, stall_cnt_d;

  assign fetch_cnt_d = fetch_cnt_q + {31'd0, load};
  assign stall_cnt_d = stall_cnt_q + {31'd0, (state_q == FETCH_HOLD)};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign perf_fetch_cnt_o = fetch_cnt_q;
  assign perf_stall_cnt_o = stall_cnt_q;
`endif

endmodule
